// File: rtl/argmin_pkg.sv
// Shared constants for the streaming argmin/argmax block family.
package argmin_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/argmin_cmp.sv
// Strict unsigned "is candidate better than best" compare; combinational, no backpressure.
module argmin_cmp
  import argmin_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] cand,
  input  logic [W-1:0] best,
  input  logic         mode,
  output logic         better
);

  // Strict compare so equal values never displace the earlier (lower-index) sample.
  assign better = (mode == MODE_MAX) ? (cand > best) : (cand < best);

endmodule

// File: rtl/stream_argmin.sv
// Frame-wise min/max finder with position; result one cycle after last accepted sample.
// Input stalls on in_valid=0; result held in DONE until out_ready, in_ready low meanwhile.
module stream_argmin
  import argmin_pkg::*;
#(
  parameter int W    = 3,
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_val,
  output logic [IDXW-1:0] out_idx,
  output logic            busy
);

  localparam logic [IDXW:0] LAST_CNT = (IDXW + 1)'(N - 1);

  logic [1:0]      state;
  logic            mode_q;
  logic [IDXW:0]   count;
  logic [W-1:0]    best_val;
  logic [IDXW-1:0] best_idx;
  logic            better;

  argmin_cmp #(.W(W)) u_cmp (
    .cand   (in_data),
    .best   (best_val),
    .mode   (mode_q),
    .better (better)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_MIN;
      count    <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            count  <= '0;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (in_valid) begin
            // First sample seeds the running best regardless of its value.
            if (count == '0 || better) begin
              best_val <= in_data;
              best_idx <= count[IDXW-1:0];
            end
            count <= count + 1'b1;
            if (count == LAST_CNT) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_SCAN);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_val   = best_val;
  assign out_idx   = best_idx;

endmodule

// File: tb/tb_stream_argmin.sv
// Directed bench for stream_argmin: N=4 frames, stalls, reset mid-frame, and an N=1 build.
module tb_stream_argmin;

  localparam int W    = 3;
  localparam int N    = 4;
  localparam int IDXW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, mode, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]    in_data, out_val;
  logic [IDXW-1:0] out_idx;

  logic            start1, mode1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W-1:0]    in_data1, out_val1;
  logic [0:0]      out_idx1;

  int checks = 0;
  int errors = 0;

  stream_argmin #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_idx(out_idx), .busy(busy)
  );

  stream_argmin #(.W(W), .N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_val(out_val1),
    .out_idx(out_idx1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // samples packed as {s3,s2,s1,s0}; gap = idle cycles between samples, hold = cycles out_ready stays low
  task automatic run_frame(input logic m, input logic [11:0] s, input int gap, input int hold,
                           input logic [2:0] ev, input logic [1:0] ei, input string tag);
    start = 1'b1; mode = m;
    tick();
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 1);
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[3*i +: 3];
      check({tag, ".early_valid"}, 32'(out_valid), 0);
      tick();
      in_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          check({tag, ".stall_ready"}, 32'(in_ready), 1);
          tick();
        end
      end
    end
    check({tag, ".out_valid"}, 32'(out_valid), 1);
    check({tag, ".out_val"}, 32'(out_val), 32'(ev));
    check({tag, ".out_idx"}, 32'(out_idx), 32'(ei));
    check({tag, ".in_ready_done"}, 32'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(out_valid), 1);
      check({tag, ".hold_val"}, 32'(out_val), 32'(ev));
      check({tag, ".hold_idx"}, 32'(out_idx), 32'(ei));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, 32'(out_valid), 0);
    check({tag, ".idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 0);
    check("rst.in_ready", 32'(in_ready), 0);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_val", 32'(out_val), 0);
    check("rst.out_idx", 32'(out_idx), 0);
    rst_n = 1'b1;
    tick();

    // 1: min of 5,2,7,3
    run_frame(1'b0, {3'd3, 3'd7, 3'd2, 3'd5}, 0, 0, 3'd2, 2'd1, "t1");
    // 2: max with tie, then all-equal min
    run_frame(1'b1, {3'd1, 3'd6, 3'd6, 3'd4}, 0, 0, 3'd6, 2'd1, "t2a");
    run_frame(1'b0, {3'd3, 3'd3, 3'd3, 3'd3}, 0, 0, 3'd3, 2'd0, "t2b");
    // 3: stalls and result backpressure
    run_frame(1'b0, {3'd0, 3'd0, 3'd7, 3'd7}, 2, 3, 3'd0, 2'd2, "t3");

    // 4: in_valid ignored in IDLE, start/mode ignored mid-frame, in_valid ignored in DONE
    in_valid = 1'b1; in_data = 3'd7;
    tick();
    tick();
    check("t4.idle_busy", 32'(busy), 0);
    check("t4.idle_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    start = 1'b1; mode = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = (i == 0) ? 3'd2 : (i == 1) ? 3'd5 : (i == 2) ? 3'd1 : 3'd4;
      mode = ~mode;
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    in_data = 3'd7;
    check("t4.out_valid", 32'(out_valid), 1);
    check("t4.out_val", 32'(out_val), 5);
    check("t4.out_idx", 32'(out_idx), 1);
    tick();
    in_valid = 1'b0;
    check("t4.done_valid", 32'(out_valid), 1);
    check("t4.done_val", 32'(out_val), 5);
    check("t4.done_idx", 32'(out_idx), 1);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("t4.handoff_valid", 32'(out_valid), 0);
    check("t4.handoff_busy", 32'(busy), 0);

    // 5: reset after two samples, then a clean frame
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 3'd4;
    tick();
    in_data = 3'd5;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5.busy", 32'(busy), 0);
    check("t5.in_ready", 32'(in_ready), 0);
    check("t5.out_valid", 32'(out_valid), 0);
    check("t5.out_val", 32'(out_val), 0);
    tick();
    check("t5.still_idle", 32'(busy), 0);
    run_frame(1'b0, {3'd3, 3'd2, 3'd0, 3'd1}, 0, 0, 3'd0, 2'd1, "t5");

    // 6: N=1 build
    start1 = 1'b1; mode1 = 1'b0;
    tick();
    start1 = 1'b0;
    check("t6.in_ready", 32'(in_ready1), 1);
    in_valid1 = 1'b1; in_data1 = 3'd5;
    tick();
    in_valid1 = 1'b0;
    check("t6.out_valid", 32'(out_valid1), 1);
    check("t6.out_val", 32'(out_val1), 5);
    check("t6.out_idx", 32'(out_idx1), 0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("t6.drop_valid", 32'(out_valid1), 0);
    check("t6.busy", 32'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_argmin.md
Name: stream_argmin

Overview:
- Parametrised sequential successor to the 4-input 3-bit minimum-position finder.
- Accepts a frame of N unsigned W-bit samples, one per handshake, over a valid/ready stream.
- Reports the extreme value (min or max, selectable per frame) and its position in the frame.
- Sits between the switch/sample capture logic and the display/result stage of the lab datapath.

Parameters:
W, 3, sample width in bits (unsigned)
N, 4, samples per frame (N >= 1)
IDXW, $clog2(N) (1 when N==1), width of the position output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  frame start pulse; sampled only in IDLE
mode  in  1  0 = find minimum, 1 = find maximum; latched on accepted start
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a sample
in_data  in  W  sample value
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_val  out  W  extreme value of the frame
out_idx  out  IDXW  position (0..N-1) of the extreme value within the frame
busy  out  1  high in every state except IDLE

Behaviour:
- Single clock domain. Synchronous active-low reset: every register is updated only on a clk rising edge with rst_n low. No asynchronous reset path.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_val=0, out_idx=0, busy=0, internal count=0, latched mode=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches mode, clears count, moves to SCAN next cycle.
  - in_valid is ignored in IDLE.
- SCAN:
  - in_ready=1. A sample is accepted on any cycle with in_valid & in_ready.
  - First sample (count==0): loads best_val=in_data, best_idx=0 unconditionally.
  - Later samples replace best only when strictly better: in_data < best_val (mode 0) or in_data > best_val (mode 1).
  - Tie rule: the lowest index wins.
  - count increments per accepted sample. On acceptance with count==N-1, the FSM goes to DONE.
  - Cycles with in_valid=0 stall the scan without changing state.
- DONE:
  - out_valid=1; out_val/out_idx hold the registered best and stay stable until the handshake.
  - in_ready=0.
  - On out_valid & out_ready, moves to IDLE next cycle and out_valid drops.
- Latency: out_valid rises on the cycle after the last sample is accepted. Minimum frame time is N+2 cycles (start, N samples, result), plus result back-pressure.
- start is ignored in SCAN and DONE. mode changes mid-frame have no effect.
- No back-to-back start in the cycle that DONE hands off; the first new start is taken in IDLE.
- N==1: one accepted sample goes straight to DONE with out_idx=0.
- Widths:
  - Comparison is unsigned, full W bits.
  - count is IDXW+1 bits wide, so count==N is representable without wrap for N a power of two.
- Reset mid-operation: rst_n low in any state returns to IDLE with the reset values next edge. A partial frame is discarded and not reported.
- out_val/out_idx keep their last value after the handshake; they are only meaningful while out_valid=1.

Decomposition:
- Shared package (argmin_pkg):
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2)
  - mode constants MODE_MIN=1'b0, MODE_MAX=1'b1
- One natural sub-module, argmin_cmp:
  - Combinational, parametrised by W.
  - Inputs cand, best, mode; output better.
  - better=1 iff cand is strictly less than best (mode 0) or strictly greater (mode 1).
  - Reused for future tree-based variants.
- The FSM, counter and best-value registers live in stream_argmin.

Test Plan:
1. W=3,N=4, mode=0, samples 5,2,7,3 with no stalls -> out_valid one cycle after the 4th accept; out_val=2, out_idx=1; busy high from the cycle after start until the handshake.
2. mode=1, samples 4,6,6,1 -> out_val=6, out_idx=1 (tie keeps lowest index). Then mode=0, samples 3,3,3,3 -> out_val=3, out_idx=0.
3. mode=0, samples 7,7,0,0 with in_valid deasserted for 2 cycles between samples and out_ready held low 3 cycles -> out_val=0, out_idx=2; outputs stable while out_ready is low; returns to IDLE the cycle after out_ready=1.
4. Assert start and toggle mode during SCAN; drive in_valid in IDLE and DONE -> no effect; result matches the mode latched at start; no extra samples counted.
5. Reset after 2 of 4 samples (rst_n low 1 cycle) -> next cycle state=IDLE, out_valid=0, busy=0, in_ready=0. A fresh frame 1,0,2,3 then gives out_val=0, out_idx=1.
6. N=1 build, sample 5 -> out_valid the next cycle, out_val=5, out_idx=0.
